// File: rtl/controladora_multicanal.sv
// Multi-channel lamp controller: presence sensors drive lamps in AUTO, a shared button selects MANUAL.
// Optional build macro CONTROLADORA_WARN_EN adds the per-channel imminent-shutdown output aviso.
module controladora_multicanal #(
    parameter int N_CH              = 4,
    parameter int TICK_DIV          = 50000,
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int AUTO_SHUTDOWN_T   = 30000
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [N_CH-1:0]                            infravermelho,
    input  logic                                       push_button,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
    output logic                                       led,
    output logic [N_CH-1:0]                            saida
`ifdef CONTROLADORA_WARN_EN
    ,
    output logic [N_CH-1:0]                            aviso
`endif
);
    localparam int CSW     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TCW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW      = $clog2(DEBOUNCE_P + 1);
    localparam int HW      = $clog2(SWITCH_MODE_MIN_T + 1);
    localparam int TW      = $clog2(AUTO_SHUTDOWN_T + 1);
    localparam int WARN_TH = AUTO_SHUTDOWN_T - AUTO_SHUTDOWN_T / 8;

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} press_state_t;

    logic [TCW-1:0]  tick_cnt_reg;
    logic            tick;
    logic [N_CH-1:0] ir_s1_reg;
    logic [N_CH-1:0] ir_s2_reg;
    logic            pb_s1_reg;
    logic            pb_s2_reg;
    logic            pb_db_reg;
    logic [DW-1:0]   db_cnt_reg;
    press_state_t    state_reg;
    logic [HW-1:0]   hold_reg;
    logic            short_press_reg;
    logic            mode_reg;
    logic            mode_next;
    logic            toggle;

    assign tick = (tick_cnt_reg == TCW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ir_s1_reg <= '0;
            ir_s2_reg <= '0;
            pb_s1_reg <= 1'b0;
            pb_s2_reg <= 1'b0;
        end else begin
            ir_s1_reg <= infravermelho;
            ir_s2_reg <= ir_s1_reg;
            pb_s1_reg <= push_button;
            pb_s2_reg <= pb_s1_reg;
        end
    end

    // Count only while the synchronized level differs from pb_db; any return to it restarts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pb_db_reg  <= 1'b0;
            db_cnt_reg <= '0;
        end else if (pb_s2_reg == pb_db_reg) begin
            db_cnt_reg <= '0;
        end else if (tick) begin
            if (db_cnt_reg == DW'(DEBOUNCE_P - 1)) begin
                pb_db_reg  <= pb_s2_reg;
                db_cnt_reg <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + DW'(1);
            end
        end
    end

    assign toggle    = (state_reg == PRESSED) && pb_db_reg && tick &&
                       (hold_reg == HW'(SWITCH_MODE_MIN_T - 1));
    assign mode_next = mode_reg ^ toggle;
    assign led       = mode_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= IDLE;
            hold_reg        <= '0;
            short_press_reg <= 1'b0;
            mode_reg        <= 1'b0;
        end else begin
            short_press_reg <= 1'b0;
            mode_reg        <= mode_next;
            case (state_reg)
                IDLE: begin
                    if (pb_db_reg) begin
                        state_reg <= PRESSED;
                        hold_reg  <= '0;
                    end
                end
                PRESSED: begin
                    if (!pb_db_reg) begin
                        short_press_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else if (toggle) begin
                        state_reg <= LONG_HELD;
                    end else if (tick) begin
                        hold_reg <= hold_reg + HW'(1);
                    end
                end
                LONG_HELD: begin
                    if (!pb_db_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic          saida_reg;
        logic          saida_next;
        logic [TW-1:0] timer_reg;
        logic [TW-1:0] timer_next;
        logic          sel_hit;

        assign sel_hit = short_press_reg && (ch_sel == CSW'(gi));

        // A mode change outranks presence and timeout events in the same cycle.
        always_comb begin
            saida_next = saida_reg;
            timer_next = timer_reg;
            if (toggle) begin
                timer_next = '0;
                if (!mode_reg) begin
                    saida_next = 1'b0;
                end
            end else if (mode_reg) begin
                if (sel_hit) begin
                    saida_next = ~saida_reg;
                end
            end else if (ir_s2_reg[gi]) begin
                saida_next = 1'b1;
                timer_next = '0;
            end else if (saida_reg && tick) begin
                if (timer_reg == TW'(AUTO_SHUTDOWN_T - 1)) begin
                    saida_next = 1'b0;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                saida_reg <= 1'b0;
                timer_reg <= '0;
            end else begin
                saida_reg <= saida_next;
                timer_reg <= timer_next;
            end
        end

        assign saida[gi] = saida_reg;

`ifdef CONTROLADORA_WARN_EN
        logic aviso_reg;

        always_ff @(posedge clk) begin
            if (!rst) begin
                aviso_reg <= 1'b0;
            end else begin
                aviso_reg <= !mode_next && saida_next && (timer_next >= TW'(WARN_TH));
            end
        end

        assign aviso[gi] = aviso_reg;
`endif
    end

endmodule
